noise_filter_ctrl: RTL and testbench
====================================

# noise_filter_ctrl

- Frame-level sequencer for the binary noise-removal pipeline: opening (erode→dilate), then closing (dilate→erode).
- Latches the filter mode at each frame start, drives per-stage enables, and qualifies 3×3 window validity from the pixel counters.
- Counts accepted pixels and drains the stage pipelines with flush cycles after the last pixel.
- Sits between the CCD capture/binarisation front end and the morphology stages.

## Interface
Parameters:
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame

Ports (one clock; reset is synchronous and active-high):
- iCLK  in  1  system pixel clock
- iRST  in  1  synchronous active-high reset
- iDVAL  in  1  pixel valid from binarisation
- iX_Cont  in  16  column of current pixel
- iY_Cont  in  16  row of current pixel
- iFrame_En  in  1  frame processing enable
- iMode  in  2  0 bypass, 1 opening, 2 closing, 3 opening+closing
- oStageEn  out  4  [0] erode1, [1] dilate1, [2] dilate2, [3] erode2
- oWinValid  out  1  current window fully inside image
- oDVAL  out  1  registered iDVAL, gated by RUN
- oFlush  out  1  synthetic valid during pipeline drain
- oBusy  out  1  high in RUN or FLUSH
- oFrameDone  out  1  one-cycle pulse at frame completion
- oSyncErr  out  1  sticky counter/coordinate mismatch

## Operation
- States: IDLE, ARM, RUN, FLUSH, DONE. After reset: IDLE, all outputs 0.
- IDLE→ARM when iFrame_En=1.
- ARM→RUN on iDVAL=1 with iX_Cont=0 and iY_Cont=0.
  - On that cycle, latch iMode into oStageEn: mode0→0000, 1→0011, 2→1100, 3→1111.
  - Latch nst = popcount(oStageEn).
  - That pixel is counted as pixel 0.
- RUN:
  - Each iDVAL increments pixel count P (width ⌈log2(IMG_W·IMG_H)⌉) and an internal x/y tracker.
  - If iX_Cont/iY_Cont ≠ tracker on a valid pixel, set oSyncErr. Processing continues.
  - oSyncErr clears only on iRST.
- RUN, on the valid pixel with P = IMG_W·IMG_H−1:
  - If nst=0, go to DONE.
  - Otherwise go to FLUSH and load drain counter D = nst·(IMG_W+1).
- FLUSH:
  - oFlush=1 every cycle; D decrements.
  - At D=1, go to DONE.
  - iDVAL is ignored: not counted, oDVAL=0.
- DONE: oFrameDone=1 for one cycle, then ARM if iFrame_En=1, else IDLE.
- oStageEn:
  - Holds from latch until the DONE cycle inclusive; cleared on entry to IDLE.
  - Retained in ARM until the next latch.
  - iMode changes outside the ARM→RUN transition cycle are ignored.
- iFrame_En low while in ARM, RUN or FLUSH: abort to IDLE next cycle. P and D are cleared, oStageEn=0, no oFrameDone.
- oWinValid = registered (iDVAL & RUN & 1≤x≤IMG_W−2 & 1≤y≤IMG_H−2), using the tracker coordinates. Border pixels carry 0, so stages treat them as background.

## Timing
- oDVAL, oWinValid: 1 cycle after the qualifying iDVAL. Both are registered and mutually aligned.
- oStageEn: valid from the cycle after the ARM→RUN transition.
- Flush length: exactly nst·(IMG_W+1) consecutive cycles, starting the cycle after the last pixel.
- oFrameDone: the cycle after the last flush cycle, or the cycle after the last pixel when nst=0.
- oBusy: combinational from state (RUN|FLUSH).
- Simultaneous last-pixel and iFrame_En low: abort takes priority.
- iRST asserted in any state: state IDLE, all outputs, counters and sticky bits 0 on the next edge.
- Back-to-back frames: the first pixel of the next frame is accepted no earlier than the cycle after DONE. A pixel arriving during DONE is dropped.

## Structure
- Shared package `noise_pkg`:
  - state enum
  - mode encodings
  - stage-enable bit indices
  - function mode→stage mask
- Sub-module `pix_tracker`: x/y/P counters with last-pixel and interior flags.
- The top holds the FSM, latches and drain counter.

## Test plan
Simulate with IMG_W=8, IMG_H=4.
- Mode 3, clean 32-pixel frame:
  - oStageEn=1111 from pixel 1.
  - 36 oFlush cycles.
  - oFrameDone one cycle after the last flush cycle.
  - oWinValid high for exactly 12 pixels.
- Mode 0 frame: no oFlush; oFrameDone the cycle after pixel 31; oStageEn=0000.
- Mode 1 latched, iMode switched to 2 at pixel 10: oStageEn stays 0011; flush lasts 18 cycles.
- iFrame_En dropped at pixel 20: IDLE next cycle; no oFrameDone; oStageEn=0000.
- iX_Cont skips at pixel 5: oSyncErr=1 and stays set through DONE until iRST.
- iRST pulsed during FLUSH: all outputs 0 next cycle; the next frame completes normally.

Source files
------------

// File: rtl/noise_pkg.sv
// Shared definitions for the binary noise-removal frame sequencer.
//   - state_e       : sequencer states (IDLE, ARM, RUN, FLUSH, DONE)
//   - MODE_*        : filter mode encodings carried on iMode
//   - STG_*         : bit positions of each morphology stage in oStageEn
//   - mode_to_mask  : filter mode -> stage enable mask
//   - stage_count   : number of enabled stages in a mask
package noise_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_OPEN   = 2'd1;
  localparam logic [1:0] MODE_CLOSE  = 2'd2;
  localparam logic [1:0] MODE_BOTH   = 2'd3;

  localparam int NUM_STAGES  = 4;
  localparam int STG_ERODE1  = 0;
  localparam int STG_DILATE1 = 1;
  localparam int STG_DILATE2 = 2;
  localparam int STG_ERODE2  = 3;

  // Opening is erode1 followed by dilate1, closing is dilate2 followed by
  // erode2. Mode bit 0 selects opening and mode bit 1 selects closing, so
  // mode 3 runs both chains back to back.
  function automatic logic [NUM_STAGES-1:0] mode_to_mask(input logic [1:0] mode);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    if (mode[0]) begin
      m[STG_ERODE1]  = 1'b1;
      m[STG_DILATE1] = 1'b1;
    end
    if (mode[1]) begin
      m[STG_DILATE2] = 1'b1;
      m[STG_ERODE2]  = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [2:0] stage_count(input logic [NUM_STAGES-1:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/noise_filter_ctrl_pix_tracker.sv
// pix_tracker: expected-coordinate and pixel counters for one frame.
// The registers always hold the coordinate and index of the NEXT pixel the
// frame expects, so the current pixel is compared against them directly.
//   clk_i      : pixel clock
//   rst_i      : synchronous active-high reset
//   clr_i      : return all counters to zero (abort / frame end)
//   start_i    : first pixel (0,0) accepted; counters move to pixel 1
//   adv_i      : a further pixel accepted; advance by one
//   x_o, y_o   : expected column/row of the current pixel
//   last_o     : current pixel is the final pixel of the frame
//   interior_o : current pixel has a complete 3x3 neighbourhood
module pix_tracker
  import noise_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        start_i,
  input  logic        adv_i,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic        last_o,
  output logic        interior_o
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX);

  localparam logic [15:0]   X_MAX  = 16'(IMG_W - 1);
  localparam logic [15:0]   Y_MAX  = 16'(IMG_H - 1);
  localparam logic [15:0]   X_INNER = 16'(IMG_W - 2);
  localparam logic [15:0]   Y_INNER = 16'(IMG_H - 2);
  localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);

  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [PW-1:0] p_q, p_d;
  logic [15:0]   base_x, base_y;
  logic [PW-1:0] base_p;

  // A start advances from (0,0)/pixel 0 regardless of stale contents, so
  // the frame is correctly aligned even if nothing cleared the counters.
  always_comb begin
    base_x = start_i ? '0 : x_q;
    base_y = start_i ? '0 : y_q;
    base_p = start_i ? '0 : p_q;
    x_d    = x_q;
    y_d    = y_q;
    p_d    = p_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
      p_d = '0;
    end else if (start_i || adv_i) begin
      if (base_x == X_MAX) begin
        x_d = '0;
        y_d = (base_y == Y_MAX) ? '0 : base_y + 16'd1;
      end else begin
        x_d = base_x + 16'd1;
      end
      p_d = base_p + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
      p_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      p_q <= p_d;
    end
  end

  assign x_o        = x_q;
  assign y_o        = y_q;
  assign last_o     = (p_q == P_LAST);
  assign interior_o = (x_q >= 16'd1) && (x_q <= X_INNER) &&
                      (y_q >= 16'd1) && (y_q <= Y_INNER);

endmodule

// File: rtl/noise_filter_ctrl.sv
// noise_filter_ctrl: frame sequencer for the opening/closing noise filter.
// Waits for frame enable, starts a frame on the pixel at (0,0), latches the
// filter mode into per-stage enables, counts pixels, then drains the stage
// pipelines with synthetic flush cycles before signalling frame completion.
//
// Pixel stream: iDVAL is a valid-only qualifier with no back-pressure; a
// pixel is consumed on every clock edge where iDVAL is high and the
// sequencer is in a state that accepts pixels (ARM for pixel 0 at (0,0),
// RUN for the rest). oDVAL/oWinValid follow one cycle later, also without
// back-pressure.
//
// Ports:
//   iCLK, iRST            : clock, synchronous active-high reset
//   iDVAL, iX_Cont/iY_Cont: binarised pixel valid and its coordinates
//   iFrame_En             : frame processing enable (low aborts a frame)
//   iMode                 : 0 bypass, 1 opening, 2 closing, 3 both
//   oStageEn              : [0] erode1 [1] dilate1 [2] dilate2 [3] erode2
//   oWinValid             : pixel has a full 3x3 window inside the image
//   oDVAL                 : registered accepted pixel valid
//   oFlush                : synthetic valid while draining the stages
//   oBusy                 : frame in RUN or FLUSH
//   oFrameDone            : one-cycle frame completion pulse
//   oSyncErr              : sticky coordinate mismatch flag
//   oDbgState             : current sequencer state (state_e encoding)
module noise_filter_ctrl
  import noise_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic        iFrame_En,
  input  logic [1:0]  iMode,
  output logic [3:0]  oStageEn,
  output logic        oWinValid,
  output logic        oDVAL,
  output logic        oFlush,
  output logic        oBusy,
  output logic        oFrameDone,
  output logic        oSyncErr,
  output logic [2:0]  oDbgState
);

  // Drain counter must hold up to NUM_STAGES * (IMG_W + 1).
  localparam int            DW         = $clog2(NUM_STAGES * (IMG_W + 1) + 1);
  localparam logic [DW-1:0] FLUSH_UNIT = DW'(IMG_W + 1);

  state_e        state_q, state_d;
  logic [3:0]    stage_en_q, stage_en_d;
  logic [2:0]    nst_q, nst_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          dval_q, dval_d;
  logic          win_q, win_d;
  logic          sync_q, sync_d;

  logic          trk_clr, trk_start, trk_adv;
  logic [15:0]   trk_x, trk_y;
  logic          trk_last, trk_interior;
  logic          first_pix;
  logic          abort;
  logic [3:0]    new_mask;

  pix_tracker #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_tracker (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .clr_i      (trk_clr),
    .start_i    (trk_start),
    .adv_i      (trk_adv),
    .x_o        (trk_x),
    .y_o        (trk_y),
    .last_o     (trk_last),
    .interior_o (trk_interior)
  );

  assign first_pix = iDVAL && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
  assign new_mask  = mode_to_mask(iMode);
  // Dropping the enable mid-frame wins over every other event, including
  // a coincident last pixel.
  assign abort     = !iFrame_En &&
                     (state_q == ST_ARM || state_q == ST_RUN || state_q == ST_FLUSH);

  always_comb begin
    state_d    = state_q;
    stage_en_d = stage_en_q;
    nst_d      = nst_q;
    drain_d    = drain_q;
    dval_d     = 1'b0;
    win_d      = 1'b0;
    sync_d     = sync_q;
    trk_clr    = 1'b0;
    trk_start  = 1'b0;
    trk_adv    = 1'b0;

    if (abort) begin
      state_d    = ST_IDLE;
      stage_en_d = '0;
      nst_d      = '0;
      drain_d    = '0;
      trk_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iFrame_En) state_d = ST_ARM;
        end
        ST_ARM: begin
          // Only the pixel at (0,0) opens a frame; it is pixel 0 and sits
          // on the border, so it never carries a valid window.
          if (first_pix) begin
            state_d    = ST_RUN;
            stage_en_d = new_mask;
            nst_d      = stage_count(new_mask);
            trk_start  = 1'b1;
            dval_d     = 1'b1;
          end
        end
        ST_RUN: begin
          if (iDVAL) begin
            dval_d  = 1'b1;
            win_d   = trk_interior;
            trk_adv = 1'b1;
            if (iX_Cont != trk_x || iY_Cont != trk_y) sync_d = 1'b1;
            if (trk_last) begin
              trk_clr = 1'b1;
              if (nst_q == 3'd0) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_FLUSH;
                drain_d = DW'(nst_q) * FLUSH_UNIT;
              end
            end
          end
        end
        ST_FLUSH: begin
          drain_d = drain_q - DW'(1);
          if (drain_q == DW'(1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          // A pixel arriving here is deliberately not looked at.
          if (iFrame_En) begin
            state_d = ST_ARM;
          end else begin
            state_d    = ST_IDLE;
            stage_en_d = '0;
            nst_d      = '0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          stage_en_d = '0;
          nst_d      = '0;
          drain_d    = '0;
          trk_clr    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      stage_en_q <= '0;
      nst_q      <= '0;
      drain_q    <= '0;
      dval_q     <= 1'b0;
      win_q      <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_en_q <= stage_en_d;
      nst_q      <= nst_d;
      drain_q    <= drain_d;
      dval_q     <= dval_d;
      win_q      <= win_d;
      sync_q     <= sync_d;
    end
  end

  assign oStageEn   = stage_en_q;
  assign oDVAL      = dval_q;
  assign oWinValid  = win_q;
  assign oSyncErr   = sync_q;
  assign oFlush     = (state_q == ST_FLUSH);
  assign oBusy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign oFrameDone = (state_q == ST_DONE);
  assign oDbgState  = state_q;

endmodule

// File: tb/tb_noise_filter_ctrl.sv
module tb_noise_filter_ctrl;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        iCLK = 1'b0;
  logic        iRST, iDVAL, iFrame_En;
  logic [15:0] iX_Cont, iY_Cont;
  logic [1:0]  iMode;
  logic [3:0]  oStageEn;
  logic        oWinValid, oDVAL, oFlush, oBusy, oFrameDone, oSyncErr;
  logic [2:0]  oDbgState;

  noise_filter_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iFrame_En(iFrame_En), .iMode(iMode), .oStageEn(oStageEn), .oWinValid(oWinValid),
    .oDVAL(oDVAL), .oFlush(oFlush), .oBusy(oBusy), .oFrameDone(oFrameDone),
    .oSyncErr(oSyncErr), .oDbgState(oDbgState)
  );

  // ---------------- clock ----------------
  always #5 iCLK = ~iCLK;

  // ---------------- scoreboard state ----------------
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];        // pixel indices sent, in order
  logic       obs_win_q[$];    // oWinValid observed with each oDVAL
  logic [3:0] obs_stage_q[$];  // oStageEn observed with each oDVAL
  int cyc, dval_seen, win_seen, flush_seen, done_seen, busy_err;
  int first_flush_cyc, last_flush_cyc, last_dval_cyc, done_cyc;
  logic [3:0] stage_at_done;
  logic       sync_at_done;
  bit keep_en, inject_b2b;

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_mask(input logic [1:0] m);
    case (m)
      2'd1:    return 4'b0011;  // erode1 + dilate1
      2'd2:    return 4'b1100;  // dilate2 + erode2
      2'd3:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int model_flush(input logic [1:0] m);
    return $countones(model_mask(m)) * (W + 1);
  endfunction

  function automatic logic model_win(input int idx);
    int x, y;
    x = idx % W;
    y = idx / W;
    return (x >= 1) && (x <= W - 2) && (y >= 1) && (y <= H - 2);
  endfunction

  // ---------------- monitor / driver tasks ----------------
  task automatic clear_mon();
    exp_q.delete(); obs_win_q.delete(); obs_stage_q.delete();
    dval_seen = 0; win_seen = 0; flush_seen = 0; done_seen = 0; busy_err = 0;
    first_flush_cyc = -1; last_flush_cyc = -1; last_dval_cyc = -1; done_cyc = -1;
    stage_at_done = 4'hx; sync_at_done = 1'bx;
  endtask

  task automatic sample();
    cyc++;
    if (oDVAL) begin
      dval_seen++;
      last_dval_cyc = cyc;
      obs_win_q.push_back(oWinValid);
      obs_stage_q.push_back(oStageEn);
      if (oWinValid) win_seen++;
    end
    if (oFlush) begin
      if (flush_seen == 0) first_flush_cyc = cyc;
      flush_seen++;
      last_flush_cyc = cyc;
      if (!oBusy) busy_err++;
    end
    if (oFrameDone) begin
      done_seen++;
      done_cyc      = cyc;
      stage_at_done = oStageEn;
      sync_at_done  = oSyncErr;
      if (!keep_en) iFrame_En = 1'b0;
      if (inject_b2b) begin
        iDVAL = 1'b1; iX_Cont = 16'd0; iY_Cont = 16'd0;
      end
    end
  endtask

  // Sample this cycle's outputs, then let one edge consume the inputs.
  task automatic cycle();
    @(negedge iCLK);
    sample();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive_frame(input logic [1:0] mode, input logic [1:0] sw_mode,
                             input int sw_at, input int skip_at, input int abort_at);
    int gaps;
    clear_mon();
    iDVAL = 1'b0; iFrame_En = 1'b1; iMode = mode;
    cycle();
    // a valid pixel not at (0,0) must not open the frame
    iDVAL = 1'b1; iX_Cont = 16'd3; iY_Cont = 16'd1;
    cycle();
    for (int i = 0; i < NPIX; i++) begin
      gaps = $urandom_range(0, 1);
      repeat (gaps) begin
        iDVAL = 1'b0; iX_Cont = 16'($urandom); iY_Cont = 16'($urandom);
        cycle();
      end
      if (i > 0) iMode = (sw_at >= 0) ? ((i >= sw_at) ? sw_mode : mode)
                                      : 2'($urandom_range(0, 3));
      if (i == abort_at) iFrame_En = 1'b0;
      iDVAL   = 1'b1;
      iX_Cont = 16'(i % W);
      iY_Cont = 16'(i / W);
      if (i == skip_at) iX_Cont = iX_Cont + 16'd1;
      if (i != abort_at) exp_q.push_back(8'(i));
      cycle();
      if (i == abort_at) begin
        iDVAL = 1'b0;
        return;
      end
    end
    iDVAL = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_seen == 0 && n < budget) begin
      iDVAL   = 1'($urandom_range(0, 1));
      iX_Cont = 16'($urandom_range(1, 5));
      iY_Cont = 16'($urandom_range(1, 5));
      cycle();
      n++;
    end
    iDVAL = 1'b0;
    total_cnt++;
    if (done_seen == 0) $display("FAIL frame_done_timeout: got none within %0d cycles, want 1", budget);
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    iRST = 1'b1; iFrame_En = 1'b1; iDVAL = 1'b1; iX_Cont = 0; iY_Cont = 0; iMode = 2'd3;
    repeat (3) begin @(posedge iCLK); #1; end
    @(negedge iCLK);
    total_cnt++; if (oStageEn !== 4'b0) $display("FAIL reset_stage: got %b want 0000", oStageEn); else pass_cnt++;
    total_cnt++; if (oDVAL !== 1'b0) $display("FAIL reset_dval: got %b want 0", oDVAL); else pass_cnt++;
    total_cnt++; if (oWinValid !== 1'b0) $display("FAIL reset_win: got %b want 0", oWinValid); else pass_cnt++;
    total_cnt++; if (oFlush !== 1'b0) $display("FAIL reset_flush: got %b want 0", oFlush); else pass_cnt++;
    total_cnt++; if (oBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", oBusy); else pass_cnt++;
    total_cnt++; if (oFrameDone !== 1'b0) $display("FAIL reset_done: got %b want 0", oFrameDone); else pass_cnt++;
    total_cnt++; if (oSyncErr !== 1'b0) $display("FAIL reset_sync: got %b want 0", oSyncErr); else pass_cnt++;
    @(posedge iCLK); #1;
    iRST = 1'b0; iFrame_En = 1'b0; iDVAL = 1'b0;
    @(posedge iCLK); #1;
  endtask

  task automatic test_mode3_frame();
    logic [7:0] idx;
    int bad_stage;
    keep_en = 0;
    drive_frame(2'd3, 2'd3, -1, -1, -1);
    wait_done(200);
    total_cnt++; if (dval_seen !== NPIX) $display("FAIL m3_dval_count: got %0d want %0d", dval_seen, NPIX); else pass_cnt++;
    total_cnt++; if (win_seen !== 12) $display("FAIL m3_win_count: got %0d want 12", win_seen); else pass_cnt++;
    total_cnt++; if (obs_win_q.size() !== exp_q.size()) $display("FAIL m3_win_len: got %0d want %0d", obs_win_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_win_q.size() > 0) begin
      idx = exp_q.pop_front();
      total_cnt++;
      if (obs_win_q[0] !== model_win(int'(idx))) $display("FAIL m3_win_px%0d: got %b want %b", idx, obs_win_q[0], model_win(int'(idx)));
      else pass_cnt++;
      void'(obs_win_q.pop_front());
    end
    bad_stage = 0;
    foreach (obs_stage_q[k]) if (obs_stage_q[k] !== 4'b1111) bad_stage++;
    total_cnt++; if (bad_stage !== 0) $display("FAIL m3_stage_en: got %0d bad samples want 0", bad_stage); else pass_cnt++;
    total_cnt++; if (flush_seen !== 36) $display("FAIL m3_flush_len: got %0d want 36", flush_seen); else pass_cnt++;
    total_cnt++; if (first_flush_cyc !== last_dval_cyc) $display("FAIL m3_flush_start: got cyc %0d want %0d", first_flush_cyc, last_dval_cyc); else pass_cnt++;
    total_cnt++; if (last_flush_cyc - first_flush_cyc + 1 !== flush_seen) $display("FAIL m3_flush_contig: got span %0d want %0d", last_flush_cyc - first_flush_cyc + 1, flush_seen); else pass_cnt++;
    total_cnt++; if (done_cyc !== last_flush_cyc + 1) $display("FAIL m3_done_time: got cyc %0d want %0d", done_cyc, last_flush_cyc + 1); else pass_cnt++;
    total_cnt++; if (stage_at_done !== 4'b1111) $display("FAIL m3_stage_at_done: got %b want 1111", stage_at_done); else pass_cnt++;
    total_cnt++; if (busy_err !== 0) $display("FAIL m3_busy_in_flush: got %0d low samples want 0", busy_err); else pass_cnt++;
    @(negedge iCLK);
    total_cnt++; if (oStageEn !== 4'b0) $display("FAIL m3_stage_idle: got %b want 0000", oStageEn); else pass_cnt++;
    @(posedge iCLK); #1;
    cycle(); cycle();
    total_cnt++; if (done_seen !== 1) $display("FAIL m3_done_pulses: got %0d want 1", done_seen); else pass_cnt++;
  endtask

  task automatic test_bypass();
    int bad_stage;
    keep_en = 0;
    drive_frame(2'd0, 2'd0, -1, -1, -1);
    wait_done(50);
    total_cnt++; if (flush_seen !== 0) $display("FAIL byp_flush: got %0d want 0", flush_seen); else pass_cnt++;
    total_cnt++; if (done_cyc !== last_dval_cyc) $display("FAIL byp_done_time: got cyc %0d want %0d", done_cyc, last_dval_cyc); else pass_cnt++;
    total_cnt++; if (dval_seen !== NPIX) $display("FAIL byp_dval_count: got %0d want %0d", dval_seen, NPIX); else pass_cnt++;
    bad_stage = 0;
    foreach (obs_stage_q[k]) if (obs_stage_q[k] !== 4'b0000) bad_stage++;
    total_cnt++; if (bad_stage !== 0) $display("FAIL byp_stage_en: got %0d bad samples want 0", bad_stage); else pass_cnt++;
  endtask

  task automatic test_mode_switch();
    int bad_stage;
    keep_en = 0;
    drive_frame(2'd1, 2'd2, 10, -1, -1);
    wait_done(200);
    bad_stage = 0;
    foreach (obs_stage_q[k]) if (obs_stage_q[k] !== 4'b0011) bad_stage++;
    total_cnt++; if (bad_stage !== 0) $display("FAIL sw_stage_en: got %0d bad samples want 0", bad_stage); else pass_cnt++;
    total_cnt++; if (flush_seen !== 18) $display("FAIL sw_flush_len: got %0d want 18", flush_seen); else pass_cnt++;
    total_cnt++; if (stage_at_done !== 4'b0011) $display("FAIL sw_stage_at_done: got %b want 0011", stage_at_done); else pass_cnt++;
  endtask

  task automatic test_abort();
    keep_en = 0;
    drive_frame(2'd3, 2'd3, -1, -1, 20);
    @(negedge iCLK);
    total_cnt++; if (oBusy !== 1'b0) $display("FAIL abort_busy: got %b want 0", oBusy); else pass_cnt++;
    total_cnt++; if (oStageEn !== 4'b0) $display("FAIL abort_stage: got %b want 0000", oStageEn); else pass_cnt++;
    total_cnt++; if (oDVAL !== 1'b0) $display("FAIL abort_pixel_dropped: got %b want 0", oDVAL); else pass_cnt++;
    @(posedge iCLK); #1;
    repeat (40) cycle();
    total_cnt++; if (done_seen !== 0) $display("FAIL abort_no_done: got %0d want 0", done_seen); else pass_cnt++;
    total_cnt++; if (flush_seen !== 0) $display("FAIL abort_no_flush: got %0d want 0", flush_seen); else pass_cnt++;
    total_cnt++; if (dval_seen !== 20) $display("FAIL abort_dval_count: got %0d want 20", dval_seen); else pass_cnt++;
  endtask

  task automatic test_sync_err();
    logic [1:0] m;
    m = 2'($urandom_range(0, 3));
    keep_en = 0;
    @(negedge iCLK);
    total_cnt++; if (oSyncErr !== 1'b0) $display("FAIL sync_before: got %b want 0", oSyncErr); else pass_cnt++;
    @(posedge iCLK); #1;
    drive_frame(m, m, -1, 5, -1);
    wait_done(200);
    total_cnt++; if (sync_at_done !== 1'b1) $display("FAIL sync_at_done: got %b want 1", sync_at_done); else pass_cnt++;
    total_cnt++; if (dval_seen !== NPIX) $display("FAIL sync_dval_count: got %0d want %0d", dval_seen, NPIX); else pass_cnt++;
    total_cnt++; if (flush_seen !== model_flush(m)) $display("FAIL sync_flush_len: got %0d want %0d", flush_seen, model_flush(m)); else pass_cnt++;
    repeat (3) cycle();
    @(negedge iCLK);
    total_cnt++; if (oSyncErr !== 1'b1) $display("FAIL sync_sticky: got %b want 1", oSyncErr); else pass_cnt++;
    @(posedge iCLK); #1;
    iRST = 1'b1; cycle(); iRST = 1'b0;
    @(negedge iCLK);
    total_cnt++; if (oSyncErr !== 1'b0) $display("FAIL sync_cleared: got %b want 0", oSyncErr); else pass_cnt++;
    @(posedge iCLK); #1;
  endtask

  task automatic test_rst_flush();
    int bad_stage;
    keep_en = 1;
    drive_frame(2'd3, 2'd3, -1, -1, -1);
    repeat (5) cycle();
    iRST = 1'b1; cycle(); iRST = 1'b0;
    @(negedge iCLK);
    total_cnt++; if (oStageEn !== 4'b0) $display("FAIL rst_stage: got %b want 0000", oStageEn); else pass_cnt++;
    total_cnt++; if ({oDVAL, oWinValid, oFlush, oBusy, oFrameDone, oSyncErr} !== 6'b0)
      $display("FAIL rst_outputs: got %b want 000000", {oDVAL, oWinValid, oFlush, oBusy, oFrameDone, oSyncErr});
    else pass_cnt++;
    @(posedge iCLK); #1;
    keep_en = 0;
    drive_frame(2'd2, 2'd2, -1, -1, -1);
    wait_done(200);
    total_cnt++; if (dval_seen !== NPIX) $display("FAIL rstf_dval_count: got %0d want %0d", dval_seen, NPIX); else pass_cnt++;
    total_cnt++; if (flush_seen !== 18) $display("FAIL rstf_flush_len: got %0d want 18", flush_seen); else pass_cnt++;
    bad_stage = 0;
    foreach (obs_stage_q[k]) if (obs_stage_q[k] !== 4'b1100) bad_stage++;
    total_cnt++; if (bad_stage !== 0) $display("FAIL rstf_stage_en: got %0d bad samples want 0", bad_stage); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] m1, m2;
    m1 = 2'($urandom_range(0, 3));
    m2 = 2'($urandom_range(0, 3));
    keep_en = 1; inject_b2b = 1;
    drive_frame(m1, m1, -1, -1, -1);
    wait_done(200);
    total_cnt++; if (flush_seen !== model_flush(m1)) $display("FAIL b2b1_flush_len: got %0d want %0d", flush_seen, model_flush(m1)); else pass_cnt++;
    total_cnt++; if (stage_at_done !== model_mask(m1)) $display("FAIL b2b1_stage_at_done: got %b want %b", stage_at_done, model_mask(m1)); else pass_cnt++;
    keep_en = 0; inject_b2b = 0;
    drive_frame(m2, m2, -1, -1, -1);
    wait_done(200);
    total_cnt++; if (dval_seen !== NPIX) $display("FAIL b2b2_dval_count: got %0d want %0d", dval_seen, NPIX); else pass_cnt++;
    total_cnt++; if (sync_at_done !== 1'b0) $display("FAIL b2b2_sync: got %b want 0", sync_at_done); else pass_cnt++;
    total_cnt++; if (flush_seen !== model_flush(m2)) $display("FAIL b2b2_flush_len: got %0d want %0d", flush_seen, model_flush(m2)); else pass_cnt++;
    total_cnt++; if (win_seen !== 12) $display("FAIL b2b2_win_count: got %0d want 12", win_seen); else pass_cnt++;
    total_cnt++; if (stage_at_done !== model_mask(m2)) $display("FAIL b2b2_stage_at_done: got %b want %b", stage_at_done, model_mask(m2)); else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    iRST = 1'b1; iDVAL = 1'b0; iFrame_En = 1'b0; iX_Cont = '0; iY_Cont = '0; iMode = '0;
    keep_en = 0; inject_b2b = 0; cyc = 0;
    clear_mon();
    test_reset();
    test_mode3_frame();
    test_bypass();
    test_mode_switch();
    test_abort();
    test_sync_err();
    test_rst_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
